// File: rtl/seven_seg_scan_driver.sv
`timescale 1ns/1ps
// Multiplexed seven-segment driver: hex or sequential-BCD decimal display with
// leading-zero blanking, overflow dash and a prescaled digit scan.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int DISP_W = 5 * NUM_DIGITS;
  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;

  // Display symbols: 0..15 are hex digits, plus blank and dash.
  localparam logic [4:0] SYM_BLANK = 5'd16;
  localparam logic [4:0] SYM_DASH  = 5'd17;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [DISP_W-1:0] build_disp(input logic [BCD_W-1:0] nib,
                                                   input logic ovf,
                                                   input logic blz);
    logic              seen;
    logic [DISP_W-1:0] d;
    seen = 1'b0;
    d    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (nib[4*i +: 4] != 4'd0) seen = 1'b1;
      if (ovf)                          d[5*i +: 5] = SYM_DASH;
      else if (blz && !seen && (i != 0)) d[5*i +: 5] = SYM_BLANK;
      else                              d[5*i +: 5] = {1'b0, nib[4*i +: 4]};
    end
    return d;
  endfunction

  function automatic logic [6:0] seg_of(input logic [4:0] sym);
    logic [6:0] s;
    case (sym)
      5'd0:     s = 7'b0111111;
      5'd1:     s = 7'b0000110;
      5'd2:     s = 7'b1011011;
      5'd3:     s = 7'b1001111;
      5'd4:     s = 7'b1100110;
      5'd5:     s = 7'b1101101;
      5'd6:     s = 7'b1111101;
      5'd7:     s = 7'b0000111;
      5'd8:     s = 7'b1111111;
      5'd9:     s = 7'b1101111;
      5'd10:    s = 7'b1110111;
      5'd11:    s = 7'b1111100;
      5'd12:    s = 7'b0111001;
      5'd13:    s = 7'b1011110;
      5'd14:    s = 7'b1111001;
      5'd15:    s = 7'b1110001;
      SYM_DASH: s = 7'b1000000;
      default:  s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [0:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;
  logic                 blz_lat;
  logic [DISP_W-1:0]    disp;
  logic [DATA_W-1:0]    sh;
  logic [BCD_W-1:0]     bcd;
  logic [PRE_W-1:0]     pre;
  logic [IDX_W-1:0]     idx;

  logic [DATA_W+BCD_W-1:0] ext;
  logic                    hex_ovf;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_nxt;
  logic                    carry;
  logic                    last;
  logic                    pre_wrap;

  assign ext      = {{BCD_W{1'b0}}, value};
  assign hex_ovf  = |(ext >> BCD_W);
  assign bcd_adj  = add3(bcd);
  assign bcd_nxt  = {bcd_adj[BCD_W-2:0], sh[DATA_W-1]};
  // A bit shifted out of the top BCD digit means the value exceeds the display.
  assign carry    = bcd_adj[BCD_W-1];
  assign last     = (cnt == CNT_W'(DATA_W - 1));
  assign pre_wrap = (pre == PRE_W'(REFRESH_DIV - 1));
  assign busy     = (state == CONVERT);

  // Control: FSM, overflow flag, latched blanking and display register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ovf     <= 1'b0;
      blz_lat <= 1'b1;
      disp    <= build_disp('0, 1'b0, 1'b1);
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            if (hex_mode) begin
              disp <= build_disp(ext[BCD_W-1:0], hex_ovf, blank_lz);
            end else begin
              state   <= CONVERT;
              cnt     <= '0;
              ovf     <= 1'b0;
              blz_lat <= blank_lz;
            end
          end
        end
        CONVERT: begin
          cnt <= cnt + 1'b1;
          ovf <= ovf | carry;
          if (last) begin
            disp  <= build_disp(bcd_nxt, ovf | carry, blz_lat);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: shift-add-3 conversion registers
  always_ff @(posedge clk) begin
    if ((state == IDLE) && load && !hex_mode) begin
      sh  <= value;
      bcd <= '0;
    end else if (state == CONVERT) begin
      sh  <= sh << 1;
      bcd <= bcd_nxt;
    end
  end

  // Scan: prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre_wrap ? '0 : pre + 1'b1;
      if (pre_wrap) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Output: select the scanned digit and apply polarity
  logic [4:0]            sym;
  logic [NUM_DIGITS-1:0] an_hi;
  logic [6:0]            seg_hi;

  always_comb begin
    sym   = SYM_BLANK;
    an_hi = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sym      = disp[5*i +: 5];
        an_hi[i] = 1'b1;
      end
    end
    seg_hi = seg_of(sym);
  end

  assign seg = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
  assign an  = (ACTIVE_LOW != 0) ? ~an_hi  : an_hi;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
`timescale 1ns/1ps
// Scoreboard bench for seven_seg_scan_driver: stimulus queues expected display
// contents with their update cycle; a monitor checks every scanned digit.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic        hex_mode;
  logic        blank_lz;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .DATA_W(14), .REFRESH_DIV(4), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .busy(busy), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [27:0] segs;
  } exp_t;

  exp_t        q[$];
  logic [27:0] cur;
  int          cyc;
  int          bs = -100;
  int          be = -100;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
      3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
      9: return 7'b1101111; 10: return 7'b1110111; 11: return 7'b1111100;
     12: return 7'b0111001; 13: return 7'b1011110; 14: return 7'b1111001;
     15: return 7'b1110001; 17: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected active-high segments for digits 3..0 of a displayed number.
  function automatic logic [27:0] exp_disp(input int v, input bit h, input bit b);
    int          dig[4];
    int          top;
    int          p;
    bit          ov;
    logic [27:0] r;
    ov  = h ? (v >= 65536) : (v > 9999);
    p   = 1;
    top = 0;
    for (int k = 0; k < 4; k++) begin
      dig[k] = h ? ((v >> (4 * k)) & 15) : ((v / p) % 10);
      p = p * 10;
      if (dig[k] != 0) top = k;
    end
    for (int k = 0; k < 4; k++)
      r[7*k +: 7] = ov ? enc(17) : ((b && k > top) ? enc(16) : enc(dig[k]));
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin : monitor
    int          k;
    exp_t        e;
    logic [3:0]  ea;
    logic [6:0]  es;
    logic        eb;
    if (!rst_n) begin
      q.delete();
      cur = exp_disp(0, 1'b0, 1'b1);
    end
    while (q.size() > 0 && q[0].due <= cyc) begin
      e   = q.pop_front();
      cur = e.segs;
    end
    k  = (cyc / 4) % 4;
    ea = ~(4'b0001 << k);
    es = ~cur[7*k +: 7];
    eb = rst_n && (cyc >= bs + 1) && (cyc <= be);
    check("an", {28'd0, an}, {28'd0, ea});
    check("seg", {25'd0, seg}, {25'd0, es});
    check("busy", {31'd0, busy}, {31'd0, eb});
  end

  task automatic do_load(input int v, input bit h, input bit b);
    exp_t e;
    @(negedge clk);
    value    = 14'(v);
    hex_mode = h;
    blank_lz = b;
    load     = 1'b1;
    if (cyc > be) begin
      e.segs = exp_disp(v, h, b);
      if (h) e.due = cyc + 1;
      else begin
        e.due = cyc + 15;
        bs    = cyc;
        be    = cyc + 14;
      end
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load     = 1'b0;
      value    = 14'($urandom);
      hex_mode = 1'($urandom);
      blank_lz = 1'($urandom);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int v;
    rst_n = 1'b0; load = 1'b0; value = '0; hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    do_load(1234, 1'b0, 1'b0);   idle(40);
    do_load('h2AF, 1'b1, 1'b1);  idle(20);
    do_load(10000, 1'b0, 1'b0);  idle(30);
    do_load(7, 1'b0, 1'b1);      idle(4);
    do_load(5, 1'b0, 1'b0);      idle(40);
    do_load(0, 1'b1, 1'b1);      idle(18);
    do_load(9999, 1'b0, 1'b1);   idle(30);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 99));
        1:       v = int'($urandom_range(9990, 10010));
        default: v = int'($urandom_range(0, 16383));
      endcase
      do_load(v, 1'($urandom), 1'($urandom));
      idle(int'($urandom_range(1, 25)));
    end
    idle(20);
    // Reset six cycles into a conversion of 9999.
    do_load(9999, 1'b0, 1'b0);
    idle(6);
    #2 rst_n = 1'b0;
    bs = -100;
    be = -100;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_an", {28'd0, an}, 32'b1110);
    check("rst_seg", {25'd0, seg}, {25'd0, ~enc(0)});
    idle(2);
    rst_n = 1'b1;
    idle(40);
    do_load('h3C, 1'b1, 1'b0);   idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DATA_W, default 14: width of the input value; legal range 4..27.
REQ-003 Parameter REFRESH_DIV, default 100000: clock cycles each digit stays lit; legal range >= 2.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means seg and an are driven active-low (Basys 3); 0 means active-high.
REQ-005 clk  input  1  single clock; every register is clocked on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 value  input  DATA_W  unsigned number to display.
REQ-008 load  input  1  one-cycle request to capture value, hex_mode and blank_lz.
REQ-009 hex_mode  input  1  1 selects hexadecimal display; 0 selects decimal display.
REQ-010 blank_lz  input  1  1 enables leading-zero blanking.
REQ-011 busy  output  1  high while a decimal conversion is in progress.
REQ-012 seg  output  7  segment drive, bit 0 = a through bit 6 = g.
REQ-013 an  output  NUM_DIGITS  digit enables, one-hot; bit 0 = rightmost digit.

Function
REQ-014 The block SHALL implement an FSM with states IDLE and CONVERT.
REQ-015 load sampled high in IDLE with hex_mode=1 SHALL update the display register on that same edge: nibble k of value goes to digit k, and the FSM stays in IDLE.
REQ-016 load sampled high in IDLE with hex_mode=0 SHALL capture value and enter CONVERT.
REQ-017 CONVERT SHALL run a sequential shift-add-3 binary-to-BCD conversion, one input bit per cycle, for exactly DATA_W cycles.
REQ-018 busy SHALL be high for exactly DATA_W cycles, starting the cycle after the load edge.
REQ-019 The display register SHALL be written atomically on the edge on which busy falls, and the FSM SHALL then return to IDLE.
REQ-020 load asserted while busy=1 SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-021 Mode and blanking SHALL be latched at load and held in the display register; later hex_mode or blank_lz changes SHALL not affect the displayed value.
REQ-022 Decimal overflow (value > 10^NUM_DIGITS - 1) SHALL show a dash (segment g only) on every digit.
REQ-023 Hex overflow (any nonzero bit of value at or above position 4*NUM_DIGITS) SHALL show a dash on every digit.
REQ-024 Digit encodings, listed as g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - dash=1000000, blank=0000000
REQ-025 With blank_lz latched at 1, every zero digit above the most significant nonzero digit SHALL show blank; digit 0 SHALL always be shown.
REQ-026 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-027 On each prescaler wrap, the scan index SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-028 an SHALL enable only the digit at the scan index; seg SHALL carry that digit's encoding, with no extra latency beyond the index and display registers.
REQ-029 With ACTIVE_LOW=1, seg and an SHALL be the bitwise inverse of the active-high values.
REQ-030 Scanning SHALL continue during CONVERT and SHALL show the previous display contents until the atomic update.
REQ-031 A load sampled on the same edge as a prescaler wrap SHALL process both events independently.

Reset
REQ-032 rst_n low SHALL immediately clear all of the following, without waiting for a clock edge:
  - FSM to IDLE, busy to 0
  - prescaler and scan index to 0
  - display register to all-zero digits, decimal mode, blank_lz=1
REQ-033 During and after reset, the outputs SHALL be: an selects digit 0, seg shows "0" (polarity applied), all other digits blank.
REQ-034 Reset asserted mid-conversion SHALL abort the conversion, and the display SHALL show "0" with no partial result.

Verification
REQ-035 Bench parameters: NUM_DIGITS=4, DATA_W=14, REFRESH_DIV=4, ACTIVE_LOW=1.
REQ-036 Decimal load of 1234, blank_lz=0 -> busy high for 14 cycles, then digits 3..0 = 1,2,3,4; digit 0 seg = ~7'b1100110 = 7'b0011001 with an=4'b1110.
REQ-037 Hex load of 0x2AF, blank_lz=1 -> display updates on the load edge with busy=0; digit 3 blank, digits 2..0 show 2, A, F.
REQ-038 Decimal load of 10000 -> after 14 cycles all four digits show dash (seg=7'b0111111 active-low).
REQ-039 Decimal load of 7, then another load 5 cycles later, then let both settle -> the second load is ignored; digit 0 shows 7, and digits 3..1 blank because blank_lz=1.
REQ-040 Scan check -> an sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles.
REQ-041 Reset check -> assert rst_n=0 at cycle 6 of a decimal conversion of 9999; busy drops at once, and the display shows "0" on digit 0 only.
